// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmit and receive blocks:
//   - baud_div()     : clock-cycles-per-bit for the 3-bit baud_set encoding
//   - PAR_*          : parity mode encodings for the PARITY parameter
//   - tx_state_e     : transmit serialiser FSM states
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Cycles per bit, rounded to nearest: (clk_freq + baud/2) / baud.
    // Always called with constant arguments so it folds to a constant.
    function automatic int unsigned baud_div(input logic [2:0]  baud_set,
                                             input int unsigned clk_freq);
        int unsigned baud;
        case (baud_set)
            3'd0:    baud = 9600;
            3'd1:    baud = 19200;
            3'd2:    baud = 38400;
            3'd3:    baud = 57600;
            3'd4:    baud = 115200;
            3'd5:    baud = 230400;
            3'd6:    baud = 460800;
            default: baud = 921600;
        endcase
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_byte_fifo
// Synchronous byte FIFO with show-ahead read data (o_rd_data always shows the
// oldest entry; i_rd_en just advances past it).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (flushes the FIFO)
//   i_wr_en     : push i_wr_data (ignored while full)
//   i_rd_en     : pop the head entry (ignored while empty)
//   o_rd_data   : head entry
//   o_full      : o_level == DEPTH
//   o_empty     : o_level == 0
//   o_level     : number of stored entries
// ---------------------------------------------------------------------------
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [7:0]               i_wr_data,
    input  logic                     i_rd_en,
    output logic [7:0]               o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_wr;
    logic          w_rd;

    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && !o_empty;

    // NOTE: storage has no reset; a flush only clears pointers and level, and
    // stale bytes are never visible because o_empty gates every read.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // Pointers wrap naturally; the level counter separates full from empty.
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW + 1)'(1);
                2'b01:   r_level <= r_level - (AW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_level == FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// Buffered UART transmitter: bytes enter a FIFO over a valid/ready handshake
// and are serialised as 8N1 / 8E1 / 8O1 frames, LSB first, on tx_dout.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   baud_set    : bit-rate select, sampled when a byte is popped
//   tx_din      : byte to send
//   tx_vld      : tx_din valid; accepted when tx_vld && tx_rdy
//   tx_rdy      : FIFO not full
//   tx_dout     : serial line, idle high (registered)
//   busy        : FIFO non-empty or a frame in progress
//   fifo_level  : bytes buffered, excluding the one in the shifter
//   overflow    : high in any cycle that tx_vld is asserted while full
// ---------------------------------------------------------------------------
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          PARITY     = PAR_NONE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2:0]                    baud_set,
    input  logic [7:0]                    tx_din,
    input  logic                          tx_vld,
    output logic                          tx_rdy,
    output logic                          tx_dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    // Slowest rate has the largest divisor; size the bit counter for it.
    localparam int DIV_W = $clog2(baud_div(3'd0, CLK_FREQ) + 1);

    tx_state_e          r_state, w_state_nxt;
    logic [DIV_W-1:0]   r_baud_cnt, w_baud_cnt_nxt;
    logic [DIV_W-1:0]   r_div, w_div_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic               r_par, w_par_nxt;
    logic               r_tx, w_tx_nxt;

    logic               w_pop;
    logic               w_bit_end;
    logic [DIV_W-1:0]   w_div_sel;
    logic [7:0]         w_fifo_data;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    uart_byte_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (tx_vld && !w_fifo_full),
        .i_wr_data  (tx_din),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_fifo_data),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_level    (fifo_level)
    );

    // Divisor lookup; each call has constant arguments, so this is a mux of
    // eight constants rather than a divider.
    always_comb begin
        w_div_sel = DIV_W'(baud_div(3'd7, CLK_FREQ));
        for (int i = 0; i < 8; i++) begin
            if (baud_set == 3'(i)) begin
                w_div_sel = DIV_W'(baud_div(3'(i), CLK_FREQ));
            end
        end
    end

    assign w_bit_end = (r_baud_cnt == r_div - DIV_W'(1));

    // NOTE: every signal driven here gets a default first so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt + DIV_W'(1);
        w_div_nxt      = r_div;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_par_nxt      = r_par;
        w_pop          = 1'b0;

        case (r_state)
            TX_IDLE: begin
                w_baud_cnt_nxt = '0;
                if (!w_fifo_empty) w_pop = 1'b1;
            end
            TX_START: begin
                if (w_bit_end) begin
                    w_state_nxt    = TX_DATA;
                    w_baud_cnt_nxt = '0;
                    w_bit_idx_nxt  = '0;
                end
            end
            TX_DATA: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    w_shift_nxt    = {1'b0, r_shift[7:1]};
                    w_bit_idx_nxt  = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
                    end
                end
            end
            TX_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt    = TX_STOP;
                    w_baud_cnt_nxt = '0;
                end
            end
            TX_STOP: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!w_fifo_empty) w_pop = 1'b1;
                    else               w_state_nxt = TX_IDLE;
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
            end
        endcase

        // Frame load: baud_set is captured here only, so a rate change never
        // disturbs a frame already on the line.
        if (w_pop) begin
            w_state_nxt    = TX_START;
            w_baud_cnt_nxt = '0;
            w_div_nxt      = w_div_sel;
            w_shift_nxt    = w_fifo_data;
            w_par_nxt      = (^w_fifo_data) ^ (PARITY == PAR_ODD);
        end

        // Line level for the next cycle, so tx_dout comes straight from a flop.
        case (w_state_nxt)
            TX_START:  w_tx_nxt = 1'b0;
            TX_DATA:   w_tx_nxt = w_shift_nxt[0];
            TX_PARITY: w_tx_nxt = w_par_nxt;
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= TX_IDLE;
            r_baud_cnt <= '0;
            r_div      <= DIV_W'(1);
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_div      <= w_div_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_par      <= w_par_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    assign tx_dout  = r_tx;
    assign tx_rdy   = !w_fifo_full;
    assign overflow = tx_vld && w_fifo_full;
    assign busy     = !w_fifo_empty || (r_state != TX_IDLE);

endmodule
